// File: rtl/mem_responder_pkg.sv
// Shared constants and FSM encoding for the line-memory responder.
package mem_responder_pkg;
   localparam int LINE_W  = 128;
   localparam int ADDR_HI = 31;
   localparam int ADDR_LO = 4;
   localparam int CNT_W   = 16;
   localparam int LAT_W   = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;
endpackage

// File: rtl/mem_line_ram.sv
// Line storage: synchronous write, combinational read, never cleared by reset.
module mem_line_ram
   import mem_responder_pkg::*;
#(
   parameter int IDX_W = 8
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  idx,
   input  logic [LINE_W-1:0] wdata,
   output logic [LINE_W-1:0] rdata
);

   logic [LINE_W-1:0] mem [2**IDX_W];

   always_ff @(posedge clk) begin
      if (we) mem[idx] <= wdata;
   end

   assign rdata = mem[idx];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency line memory responder: accepts one read/write in IDLE,
// waits LATENCY cycles, then pulses mem_ready for one cycle.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int LATENCY = 4,
   parameter int IDX_W   = 8
) (
   input  logic                  clk,
   input  logic                  proc_reset,
   input  logic                  mem_read,
   input  logic                  mem_write,
   input  logic [ADDR_HI:ADDR_LO] mem_addr,
   input  logic [LINE_W-1:0]     mem_wdata,
   output logic [LINE_W-1:0]     mem_rdata,
   output logic                  mem_ready,
   output logic                  proto_err,
   output logic [CNT_W-1:0]      rd_cnt,
   output logic [CNT_W-1:0]      wr_cnt
);

   // Handshake: the cache holds mem_read/mem_write (level) until mem_ready;
   // a request is accepted only in IDLE, mem_ready is a one-cycle pulse in
   // RESP, and any request seen in BUSY or RESP is ignored.

   localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(LATENCY - 1);

   state_t              state_q, state_d;
   logic [LAT_W-1:0]    lat_q;
   logic                op_wr_q;
   logic [IDX_W-1:0]    idx_q;
   logic [LINE_W-1:0]   wdata_q;
   logic                proto_err_q;
   logic [CNT_W-1:0]    rd_cnt_q, wr_cnt_q;
   logic [LINE_W-1:0]   ram_rdata;
   logic                ram_we;
   logic                req;
   logic                accept;
   logic                unused_addr_hi;

   // Upper address bits are deliberately dropped so lines alias.
   assign unused_addr_hi = ^mem_addr[ADDR_HI:ADDR_LO+IDX_W];

   assign req    = mem_read | mem_write;
   assign accept = (state_q == IDLE) && req;

   always_ff @(posedge clk) begin
      if (proc_reset) state_q <= IDLE;
      else            state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (req) state_d = (LAT_LOAD == '0) ? RESP : BUSY;
         end
         BUSY: begin
            if (lat_q <= LAT_W'(1)) state_d = RESP;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_ready = 1'b0;
      mem_rdata = '0;
      ram_we    = 1'b0;
      proto_err = proto_err_q;
      rd_cnt    = rd_cnt_q;
      wr_cnt    = wr_cnt_q;
      if (state_q == RESP) begin
         mem_ready = 1'b1;
         if (op_wr_q) ram_we    = ~proc_reset;
         else         mem_rdata = ram_rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (proc_reset) begin
         lat_q       <= '0;
         proto_err_q <= 1'b0;
      end else begin
         proto_err_q <= accept & mem_read & mem_write;
         if (accept)                lat_q <= LAT_LOAD;
         else if (state_q == BUSY)  lat_q <= lat_q - LAT_W'(1);
      end
   end

   // Dual read+write requests resolve to a write.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_wr_q <= mem_write;
         idx_q   <= mem_addr[ADDR_LO +: IDX_W];
         wdata_q <= mem_wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (proc_reset) begin
         rd_cnt_q <= '0;
         wr_cnt_q <= '0;
      end else if (state_q == RESP) begin
         if (op_wr_q) wr_cnt_q <= wr_cnt_q + CNT_W'(1);
         else         rd_cnt_q <= rd_cnt_q + CNT_W'(1);
      end
   end

   mem_line_ram #(.IDX_W(IDX_W)) u_ram (
      .clk   (clk),
      .we    (ram_we),
      .idx   (idx_q),
      .wdata (wdata_q),
      .rdata (ram_rdata)
   );

endmodule
